tomasulo_fetch_unit: RTL and testbench

- 3-wide in-order fetch stage; it is the transmitter for the decoder's fetch_instruction / fetch_pc / fetch_valid interface.
- Owns the PC and issues bundle requests to instruction memory.
- Buffers returned bundles in a small fetch queue and presents the head bundle to decode under dec_rdy backpressure.
- On flush, redirects to a new PC and discards all queued and in-flight bundles.

---
 rtl/tomasulo_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_tomasulo_fetch_unit.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tomasulo_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tomasulo_fetch_unit
// Description : 3-wide in-order fetch stage with credit-based imem requests, a
//               bundle fetch queue and flush-time discard of stale responses.
//               Optional perf counters are enabled by FETCH_PERF_CNT_EN.
// Revision    : 1.0
// ============================================================================
module tomasulo_fetch_unit #(
    parameter int          ISSUE_WIDTH = 3,
    parameter int          FQ_DEPTH    = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic [31:0]               redirect_pc,
    output logic                      imem_req_valid,
    output logic [31:0]               imem_req_addr,
    input  logic                      imem_req_ready,
    input  logic                      imem_resp_valid,
    input  logic [ISSUE_WIDTH*32-1:0] imem_resp_data,
    input  logic [ISSUE_WIDTH-1:0]    dec_rdy,
    output logic [ISSUE_WIDTH*32-1:0] fetch_instruction,
    output logic [ISSUE_WIDTH*32-1:0] fetch_pc,
    output logic [ISSUE_WIDTH-1:0]    fetch_valid,
    output logic                      fetch_stall
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]               perf_bundles_out,
    output logic [31:0]               perf_stall_cycles
`endif
);

    localparam int          c_PTR_W        = $clog2(FQ_DEPTH);
    localparam int          c_CNT_W        = c_PTR_W + 1;
    localparam int          c_SUM_W        = c_CNT_W + 2;
    localparam logic [31:0] c_BUNDLE_BYTES = 32'(4 * ISSUE_WIDTH);

    logic [31:0]               r_pc;
    logic [ISSUE_WIDTH*32-1:0] r_fq_data [FQ_DEPTH];
    logic [31:0]               r_fq_pc   [FQ_DEPTH];
    logic [31:0]               r_rp_pc   [FQ_DEPTH];
    logic [c_PTR_W-1:0]        r_head;
    logic [c_PTR_W-1:0]        r_tail;
    logic [c_PTR_W-1:0]        r_rp_head;
    logic [c_PTR_W-1:0]        r_rp_tail;
    logic [c_CNT_W-1:0]        r_count;
    logic [c_CNT_W-1:0]        r_outstanding;
    logic [c_CNT_W-1:0]        r_drop_cnt;

    logic [c_SUM_W-1:0] w_credit_sum;
    logic               w_empty;
    logic               w_transfer;
    logic               w_accept;
    logic               w_drop;
    logic               w_push;

    // Stale in-flight bundles still occupy credits until they are discarded.
    assign w_credit_sum   = c_SUM_W'(r_count) + c_SUM_W'(r_outstanding) + c_SUM_W'(r_drop_cnt);
    assign w_empty        = (r_count == '0);
    assign w_transfer     = !w_empty && (&dec_rdy) && !flush;
    assign imem_req_valid = reset_n && !flush && (w_credit_sum < c_SUM_W'(FQ_DEPTH));
    assign imem_req_addr  = r_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;
    assign w_drop         = imem_resp_valid && (r_drop_cnt != '0);
    assign w_push         = imem_resp_valid && !w_drop && !flush;
    assign fetch_stall    = w_empty;

    for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_lane
        assign fetch_instruction[i*32 +: 32] = w_empty ? 32'h0 : r_fq_data[r_head][i*32 +: 32];
        assign fetch_pc[i*32 +: 32]          = w_empty ? 32'h0 : r_fq_pc[r_head] + 32'(4 * i);
        assign fetch_valid[i]                = w_transfer;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc          <= RESET_PC;
            r_head        <= '0;
            r_tail        <= '0;
            r_rp_head     <= '0;
            r_rp_tail     <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else if (flush) begin
            // A response landing in the flush cycle is itself discarded.
            r_pc          <= redirect_pc;
            r_head        <= '0;
            r_tail        <= '0;
            r_rp_head     <= '0;
            r_rp_tail     <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= r_drop_cnt + r_outstanding - c_CNT_W'(imem_resp_valid);
        end else begin
            if (w_accept) begin
                r_pc      <= r_pc + c_BUNDLE_BYTES;
                r_rp_tail <= r_rp_tail + 1'b1;
            end
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt - 1'b1;
            end
            if (w_push) begin
                r_tail    <= r_tail + 1'b1;
                r_rp_head <= r_rp_head + 1'b1;
            end
            if (w_transfer) begin
                r_head <= r_head + 1'b1;
            end
            r_count       <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_transfer);
            r_outstanding <= r_outstanding + c_CNT_W'(w_accept) - c_CNT_W'(w_push);
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rp_pc[r_rp_tail] <= r_pc;
        end
        if (w_push) begin
            r_fq_data[r_tail] <= imem_resp_data;
            r_fq_pc[r_tail]   <= r_rp_pc[r_rp_head];
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_bundles;
    logic [31:0] r_perf_stalls;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_bundles <= '0;
            r_perf_stalls  <= '0;
        end else begin
            if (w_transfer && (r_perf_bundles != '1)) begin
                r_perf_bundles <= r_perf_bundles + 1'b1;
            end
            if (w_empty && !flush && (r_perf_stalls != '1)) begin
                r_perf_stalls <= r_perf_stalls + 1'b1;
            end
        end
    end

    assign perf_bundles_out  = r_perf_bundles;
    assign perf_stall_cycles = r_perf_stalls;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tomasulo_fetch_unit.sv
`default_nettype none
// Bench for tomasulo_fetch_unit: directed vector table, hand sequences and a
// randomized run against an epoch-tagged in-order imem/fetch-queue model.
module tb_tomasulo_fetch_unit;

    localparam int          IW    = 3;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            flush;
    logic [31:0]     redirect_pc;
    logic            imem_req_valid;
    logic [31:0]     imem_req_addr;
    logic            imem_req_ready;
    logic            imem_resp_valid;
    logic [IW*32-1:0] imem_resp_data;
    logic [IW-1:0]   dec_rdy;
    logic [IW*32-1:0] fetch_instruction;
    logic [IW*32-1:0] fetch_pc;
    logic [IW-1:0]   fetch_valid;
    logic            fetch_stall;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]     perf_bundles_out;
    logic [31:0]     perf_stall_cycles;
`endif

    always #5 clk = ~clk;

    tomasulo_fetch_unit #(.ISSUE_WIDTH(IW), .FQ_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .flush             (flush),
        .redirect_pc       (redirect_pc),
        .imem_req_valid    (imem_req_valid),
        .imem_req_addr     (imem_req_addr),
        .imem_req_ready    (imem_req_ready),
        .imem_resp_valid   (imem_resp_valid),
        .imem_resp_data    (imem_resp_data),
        .dec_rdy           (dec_rdy),
        .fetch_instruction (fetch_instruction),
        .fetch_pc          (fetch_pc),
        .fetch_valid       (fetch_valid),
        .fetch_stall       (fetch_stall)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_bundles_out  (perf_bundles_out),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // imem model: accepted requests in order, each tagged with the flush epoch
    logic [31:0] q_addr [$];
    int          q_epoch[$];
    int          q_due  [$];
    logic [31:0] m_fq   [$];
    logic [31:0] m_pc;
    int          epoch  = 0;
    int          lat    = 1;
    bit          resp_en = 1'b1;
    int          m_perf_xfer  = 0;
    int          m_perf_stall = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3C3_5A5A;
    endfunction

    function automatic logic [IW*32-1:0] bundle_of(input logic [31:0] a);
        logic [IW*32-1:0] b;
        for (int i = 0; i < IW; i++) b[i*32 +: 32] = word_of(a + 32'(4 * i));
        return b;
    endfunction

    function automatic logic [IW*32-1:0] pcs_of(input logic [31:0] a);
        logic [IW*32-1:0] b;
        for (int i = 0; i < IW; i++) b[i*32 +: 32] = a + 32'(4 * i);
        return b;
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_and_settle();
        if (q_addr.size() > 0 && q_due[0] <= cyc && resp_en && reset_n) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = bundle_of(q_addr[0]);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        #4;
    endtask

    task automatic compare_model();
        bit e_reqv;
        bit e_xfer;
        e_reqv = !flush && ((m_fq.size() + q_addr.size()) < DEPTH);
        e_xfer = (m_fq.size() > 0) && (&dec_rdy) && !flush;
        chk("req_valid", 96'(imem_req_valid), 96'(e_reqv));
        if (e_reqv) chk("req_addr", 96'(imem_req_addr), 96'(m_pc));
        chk("fetch_valid", 96'(fetch_valid), 96'({IW{e_xfer}}));
        chk("fetch_stall", 96'(fetch_stall), 96'(m_fq.size() == 0));
        if (m_fq.size() > 0) begin
            chk("fetch_pc", 96'(fetch_pc), 96'(pcs_of(m_fq[0])));
            chk("fetch_instr", 96'(fetch_instruction), 96'(bundle_of(m_fq[0])));
        end else begin
            chk("fetch_pc_empty", 96'(fetch_pc), 96'h0);
            chk("fetch_instr_empty", 96'(fetch_instruction), 96'h0);
        end
    endtask

    task automatic update_model();
        bit          e_reqv;
        bit          e_xfer;
        logic [31:0] a;
        int          ep;
        e_reqv = !flush && ((m_fq.size() + q_addr.size()) < DEPTH);
        e_xfer = (m_fq.size() > 0) && (&dec_rdy) && !flush;
        if (m_fq.size() == 0 && !flush) m_perf_stall++;
        a  = '0;
        ep = -1;
        if (imem_resp_valid) begin
            a  = q_addr.pop_front();
            ep = q_epoch.pop_front();
            void'(q_due.pop_front());
        end
        if (e_xfer) begin
            void'(m_fq.pop_front());
            m_perf_xfer++;
        end
        if (imem_resp_valid && ep == epoch && !flush) m_fq.push_back(a);
        if (flush) begin
            m_fq.delete();
            epoch++;
            m_pc = redirect_pc;
        end else if (e_reqv && imem_req_ready) begin
            q_addr.push_back(m_pc);
            q_epoch.push_back(epoch);
            q_due.push_back(cyc + lat);
            m_pc = m_pc + 32'd12;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        drive_and_settle();
        compare_model();
        update_model();
        advance();
    endtask

    task automatic wait_first(input logic [31:0] exp_pc, input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            drive_and_settle();
            compare_model();
            if (fetch_valid == 3'b111) begin
                chk(name, 96'(fetch_pc[31:0]), 96'(exp_pc));
                seen = 1'b1;
            end
            update_model();
            advance();
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: no bundle delivered within 40 cycles, expected pc %h", name, exp_pc);
        end
    endtask

    typedef struct {
        logic [2:0]  rdy;
        logic        ready;
        logic        e_req_valid;
        logic [31:0] e_req_addr;
        logic [2:0]  e_fvalid;
        logic [31:0] e_pc0;
        logic        e_stall;
    } vec_t;

    vec_t vecs[6];

    initial begin
        reset_n = 1'b0; flush = 1'b0; redirect_pc = '0; imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0; imem_resp_data = '0; dec_rdy = 3'b111;
        m_pc = RPC;

        vecs[0] = '{3'b111, 1'b1, 1'b1, 32'h00, 3'b000, 32'h00, 1'b1};
        vecs[1] = '{3'b111, 1'b1, 1'b1, 32'h0C, 3'b000, 32'h00, 1'b1};
        vecs[2] = '{3'b111, 1'b1, 1'b1, 32'h18, 3'b111, 32'h00, 1'b0};
        vecs[3] = '{3'b111, 1'b1, 1'b1, 32'h24, 3'b111, 32'h0C, 1'b0};
        vecs[4] = '{3'b111, 1'b1, 1'b1, 32'h30, 3'b111, 32'h18, 1'b0};
        vecs[5] = '{3'b111, 1'b1, 1'b1, 32'h3C, 3'b111, 32'h24, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", 96'(imem_req_valid), 96'h0);
        chk("rst_fetch_valid", 96'(fetch_valid), 96'h0);
        chk("rst_fetch_stall", 96'(fetch_stall), 96'h1);
        chk("rst_fetch_pc", 96'(fetch_pc), 96'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Streaming from reset with 1-cycle imem
        lat = 1;
        for (int v = 0; v < 6; v++) begin
            dec_rdy = vecs[v].rdy;
            imem_req_ready = vecs[v].ready;
            drive_and_settle();
            chk("tbl_req_valid", 96'(imem_req_valid), 96'(vecs[v].e_req_valid));
            chk("tbl_req_addr", 96'(imem_req_addr), 96'(vecs[v].e_req_addr));
            chk("tbl_fetch_valid", 96'(fetch_valid), 96'(vecs[v].e_fvalid));
            chk("tbl_fetch_pc0", 96'(fetch_pc[31:0]), 96'(vecs[v].e_pc0));
            chk("tbl_fetch_stall", 96'(fetch_stall), 96'(vecs[v].e_stall));
            compare_model();
            update_model();
            advance();
        end

        // Partial decoder ready: no lane may be offered, queue fills
        dec_rdy = 3'b011;
        repeat (5) step();
        dec_rdy = 3'b111;
        drive_and_settle();
        chk("bp_req_valid_full", 96'(imem_req_valid), 96'h0);
        chk("bp_release_valid", 96'(fetch_valid), 96'h7);
        compare_model();
        update_model();
        advance();
        repeat (8) step();

        // imem not ready: pc holds and the queue drains to a stall
        imem_req_ready = 1'b0;
        repeat (10) step();
        chk("nr_stall", 96'(fetch_stall), 96'h1);
        chk("nr_addr_hold", 96'(imem_req_addr), 96'(m_pc));

        // Flush while bundles are queued and requests are in flight
        imem_req_ready = 1'b1;
        dec_rdy = 3'b000;
        lat = 4;
        repeat (6) step();
        flush = 1'b1; redirect_pc = 32'h100;
        step();
        flush = 1'b0;
        drive_and_settle();
        chk("fl_valid_after", 96'(fetch_valid), 96'h0);
        compare_model();
        update_model();
        advance();
        dec_rdy = 3'b111;
        wait_first(32'h100, "fl_first_pc");
        repeat (6) step();

        // Response arriving in the flush cycle with one request outstanding
        imem_req_ready = 1'b0;
        lat = 1;
        repeat (8) step();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        flush = 1'b1; redirect_pc = 32'h200;
        drive_and_settle();
        chk("fr_resp_in_flush", 96'(imem_resp_valid), 96'h1);
        compare_model();
        update_model();
        advance();
        flush = 1'b0;
        imem_req_ready = 1'b1;
        drive_and_settle();
        chk("fr_req_after", 96'(imem_req_valid), 96'h1);
        chk("fr_addr_after", 96'(imem_req_addr), 96'h200);
        compare_model();
        update_model();
        advance();
        wait_first(32'h200, "fr_first_pc");

        // Back-to-back flushes: last redirect wins
        lat = 3;
        repeat (3) step();
        flush = 1'b1; redirect_pc = 32'h300; step();
        redirect_pc = 32'h400; step();
        flush = 1'b0;
        wait_first(32'h400, "bb_first_pc");

        // Async reset with a full queue
        dec_rdy = 3'b000;
        lat = 1;
        repeat (8) step();
        chk("mr_full_stall", 96'(fetch_stall), 96'h0);
        dec_rdy = 3'b111;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_fetch_valid", 96'(fetch_valid), 96'h0);
        chk("mr_stall", 96'(fetch_stall), 96'h1);
        chk("mr_req_valid", 96'(imem_req_valid), 96'h0);
        q_addr.delete(); q_epoch.delete(); q_due.delete(); m_fq.delete();
        m_pc = RPC; m_perf_xfer = 0; m_perf_stall = 0;
        imem_resp_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive_and_settle();
        chk("mr_restart_addr", 96'(imem_req_addr), 96'(RPC));
        compare_model();
        update_model();
        advance();
        wait_first(RPC, "mr_first_pc");

        // Randomized run
        for (int n = 0; n < 3000; n++) begin
            dec_rdy        = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            imem_req_ready = ($urandom_range(0, 4) != 0);
            flush          = ($urandom_range(0, 30) == 0);
            redirect_pc    = $urandom & 32'hFFFF_FFFC;
            resp_en        = ($urandom_range(0, 5) != 0);
            lat            = $urandom_range(1, 3);
            step();
        end
        flush = 1'b0;
        resp_en = 1'b1;

`ifdef FETCH_PERF_CNT_EN
        drive_and_settle();
        chk("perf_bundles", 96'(perf_bundles_out), 96'(m_perf_xfer));
        chk("perf_stalls", 96'(perf_stall_cycles), 96'(m_perf_stall));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
